// File: rtl/fifomult2024_arb.sv
// Two-requester round-robin front end for a word-serial multiplier.
// Sends A then B, waits for the product, returns it or a timeout pulse.
module fifomult2024_arb #(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         rq_valid,
  output logic [1:0]         rq_ready,
  input  logic [31:0]        rq_a,
  input  logic [31:0]        rq_b,
  input  logic [1:0]         rq_a_par,
  input  logic [1:0]         rq_b_par,
  output logic [1:0]         rs_valid,
  output logic [1:0]         rs_timeout,
  output logic [31:0]        rs_data,
  output logic               rs_parity,
  output logic               rs_par_err,
  output logic signed [15:0] m_data_in,
  output logic               m_data_in_parity,
  output logic               m_data_in_valid,
  input  logic               m_busy_out,
  input  logic [31:0]        m_data_out,
  input  logic               m_data_out_parity,
  input  logic               m_data_out_valid,
  input  logic               m_data_in_parity_error,
  output logic               arb_busy
);

  localparam int CW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_RES
  } state_t;

  state_t state, state_n;

  logic                last, last_n;
  logic                gnt, gnt_n;
  logic [15:0]         b_q, b_n;
  logic                bp_q, bp_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic signed [15:0]  din_n;
  logic                dinp_n;
  logic                dinv_n;
  logic [31:0]         rs_data_n;
  logic                rs_parity_n;
  logic                rs_par_err_n;
  logic [1:0]          rs_valid_n;
  logic [1:0]          rs_timeout_n;
  logic                both;
  logic                pick;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    both = &rq_valid;
    pick = 1'b0;
    unique case (1'b1)
      both:                        pick = ~last;
      rq_valid[1] & ~rq_valid[0]:  pick = 1'b1;
      default:                     pick = 1'b0;
    endcase
  end

  always_comb begin
    rq_ready = 2'b00;
    if (rst_n && state == IDLE && |rq_valid) begin
      rq_ready = pick ? 2'b10 : 2'b01;
    end
  end

  assign arb_busy = (state != IDLE);

  always_comb begin
    state_n      = state;
    last_n       = last;
    gnt_n        = gnt;
    b_n          = b_q;
    bp_n         = bp_q;
    cnt_n        = cnt;
    din_n        = m_data_in;
    dinp_n       = m_data_in_parity;
    dinv_n       = m_data_in_valid;
    rs_data_n    = rs_data;
    rs_parity_n  = rs_parity;
    rs_par_err_n = rs_par_err;
    rs_valid_n   = 2'b00;
    rs_timeout_n = 2'b00;
    unique case (state)
      IDLE: begin
        if (|rq_valid) begin
          gnt_n   = pick;
          last_n  = pick;
          din_n   = pick ? rq_a[31:16] : rq_a[15:0];
          dinp_n  = rq_a_par[pick];
          dinv_n  = 1'b1;
          b_n     = pick ? rq_b[31:16] : rq_b[15:0];
          bp_n    = rq_b_par[pick];
          state_n = SEND_A;
        end
      end
      SEND_A: begin
        if (!m_busy_out) begin
          din_n   = b_q;
          dinp_n  = bp_q;
          state_n = SEND_B;
        end
      end
      SEND_B: begin
        if (!m_busy_out) begin
          dinv_n  = 1'b0;
          cnt_n   = '0;
          state_n = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A result landing on the last allowed cycle still wins.
        if (m_data_out_valid) begin
          rs_data_n    = m_data_out;
          rs_parity_n  = m_data_out_parity;
          rs_par_err_n = m_data_in_parity_error;
          rs_valid_n   = gnt ? 2'b10 : 2'b01;
          state_n      = IDLE;
        end else if (cnt == CNT_MAX) begin
          rs_timeout_n = gnt ? 2'b10 : 2'b01;
          state_n      = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last             <= 1'b1;
      gnt              <= 1'b0;
      b_q              <= '0;
      bp_q             <= 1'b0;
      cnt              <= '0;
      m_data_in        <= '0;
      m_data_in_parity <= 1'b0;
      m_data_in_valid  <= 1'b0;
      rs_data          <= '0;
      rs_parity        <= 1'b0;
      rs_par_err       <= 1'b0;
      rs_valid         <= 2'b00;
      rs_timeout       <= 2'b00;
    end else begin
      state            <= state_n;
      last             <= last_n;
      gnt              <= gnt_n;
      b_q              <= b_n;
      bp_q             <= bp_n;
      cnt              <= cnt_n;
      m_data_in        <= din_n;
      m_data_in_parity <= dinp_n;
      m_data_in_valid  <= dinv_n;
      rs_data          <= rs_data_n;
      rs_parity        <= rs_parity_n;
      rs_par_err       <= rs_par_err_n;
      rs_valid         <= rs_valid_n;
      rs_timeout       <= rs_timeout_n;
    end
  end

endmodule

// File: tb/tb_fifomult2024_arb.sv
// Scoreboard bench for fifomult2024_arb with a behavioural multiplier.
// Directed operations; a negedge monitor pops and compares expectations.
module tb_fifomult2024_arb;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rq_valid, rq_ready;
  logic [31:0]        rq_a, rq_b;
  logic [1:0]         rq_a_par, rq_b_par;
  logic [1:0]         rs_valid, rs_timeout;
  logic [31:0]        rs_data;
  logic               rs_parity, rs_par_err;
  logic signed [15:0] m_data_in;
  logic               m_data_in_parity, m_data_in_valid;
  logic               m_busy_out;
  logic [31:0]        m_data_out;
  logic               m_data_out_parity, m_data_out_valid;
  logic               m_data_in_parity_error;
  logic               arb_busy;

  logic        rqv0 = 0, rqv1 = 0;
  logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        ap0 = 0, bp0 = 0, ap1 = 0, bp1 = 0;

  assign rq_valid = {rqv1, rqv0};
  assign rq_a     = {a1, a0};
  assign rq_b     = {b1, b0};
  assign rq_a_par = {ap1, ap0};
  assign rq_b_par = {bp1, bp0};

  fifomult2024_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_a(rq_a), .rq_b(rq_b),
    .rq_a_par(rq_a_par), .rq_b_par(rq_b_par),
    .rs_valid(rs_valid), .rs_timeout(rs_timeout),
    .rs_data(rs_data), .rs_parity(rs_parity),
    .rs_par_err(rs_par_err),
    .m_data_in(m_data_in),
    .m_data_in_parity(m_data_in_parity),
    .m_data_in_valid(m_data_in_valid),
    .m_busy_out(m_busy_out),
    .m_data_out(m_data_out),
    .m_data_out_parity(m_data_out_parity),
    .m_data_out_valid(m_data_out_valid),
    .m_data_in_parity_error(m_data_in_parity_error),
    .arb_busy(arb_busy)
  );

  typedef struct {
    logic [15:0] d;
    logic        p;
  } word_t;

  typedef struct {
    int          r;
    bit          to;
    logic [31:0] d;
    logic        p;
    logic        e;
  } resp_t;

  int    gq[$];
  word_t wq[$];
  resp_t rq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Behavioural multiplier: takes A then B, answers after lat cycles.
  int   lat = 2;
  int   arm_busy = 0;
  bit   drop_result = 0;
  int   n_results = 0;
  int   busy_left = 0;
  bit   have_a = 0;
  bit   pend = 0;
  int   pcnt = 0;
  logic [15:0] wa, wb, cw;
  logic        pa, pb, cp;
  bit          cap, sb;
  logic signed [31:0] prod;

  initial begin
    m_busy_out = 0;
    m_data_out = '0;
    m_data_out_parity = 0;
    m_data_out_valid = 0;
    m_data_in_parity_error = 0;
    forever begin
      @(negedge clk);
      cap = m_data_in_valid && !m_busy_out;
      cw  = m_data_in;
      cp  = m_data_in_parity;
      sb  = (rq_ready != 2'b00) && (arm_busy > 0);
      @(posedge clk);
      #1;
      m_data_out_valid = 0;
      m_data_in_parity_error = 0;
      if (pend) begin
        if (pcnt == 0) begin
          prod = $signed(wa) * $signed(wb);
          m_data_out = prod;
          m_data_out_parity = ^prod;
          m_data_in_parity_error = ((^wa) != pa) || ((^wb) != pb);
          m_data_out_valid = 1;
          pend = 0;
          n_results++;
        end else begin
          pcnt--;
        end
      end
      if (cap) begin
        if (!have_a) begin
          wa = cw; pa = cp; have_a = 1;
        end else begin
          wb = cw; pb = cp; have_a = 0;
          if (!drop_result) begin
            pend = 1; pcnt = lat;
          end
        end
      end
      if (sb) begin
        busy_left = arm_busy;
        arm_busy = 0;
      end
      m_busy_out = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  int    gcyc = 0, ax_cyc = 0, bx_cyc = 0, dv_cyc = 0;
  bit    first_seen = 1, wsel = 0, word_held = 0, busy_chk = 0;
  int    hold_cnt = 0;
  logic [31:0] last_data = '0;
  int    g;
  word_t w;
  resp_t e;

  always @(negedge clk) begin
    if (busy_chk) begin
      busy_chk = 0;
      chk(!arb_busy, "idle_after_timeout", 32'(arb_busy), 0);
    end
    if (rst_n) begin
      if (rq_ready != 2'b00) begin
        if (gq.size() == 0) begin
          chk(0, "grant_unexpected", 32'(rq_ready), 0);
        end else begin
          g = gq.pop_front();
          chk(rq_ready == (2'b01 << g), "grant",
              32'(rq_ready), 32'(2'b01 << g));
        end
        gcyc = cyc;
        first_seen = 0;
      end
      if (m_data_in_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          chk(cyc == gcyc + 1, "a_latency", 32'(cyc - gcyc), 1);
        end
        if (wq.size() == 0) begin
          chk(0, "word_unexpected", 32'(m_data_in), 0);
        end else begin
          w = wq[0];
          chk(m_data_in == w.d && m_data_in_parity == w.p,
              m_busy_out ? "word_hold" : "word",
              {15'd0, m_data_in_parity, m_data_in},
              {15'd0, w.p, w.d});
          if (m_busy_out) begin
            hold_cnt++;
            word_held = 1;
          end else begin
            void'(wq.pop_front());
            if (!wsel) begin
              ax_cyc = cyc;
            end else begin
              bx_cyc = cyc + 1;
              if (!word_held)
                chk(cyc == ax_cyc + 1, "b_follows_a",
                    32'(cyc - ax_cyc), 1);
            end
            wsel = ~wsel;
            word_held = 0;
          end
        end
      end
      if (rs_valid != 2'b00 || rs_timeout != 2'b00) begin
        if (rq.size() == 0) begin
          chk(0, "response_unexpected", 32'({rs_timeout, rs_valid}), 0);
        end else begin
          e = rq.pop_front();
          if (e.to) begin
            chk(rs_timeout == (2'b01 << e.r) && rs_valid == 2'b00,
                "timeout_pulse", 32'({rs_timeout, rs_valid}),
                32'({2'b01 << e.r, 2'b00}));
            chk(cyc - bx_cyc == TO, "timeout_gap",
                32'(cyc - bx_cyc), TO);
            chk(rs_data == last_data, "data_hold", rs_data, last_data);
            busy_chk = 1;
          end else begin
            chk(rs_valid == (2'b01 << e.r) && rs_timeout == 2'b00,
                "valid_pulse", 32'({rs_timeout, rs_valid}),
                32'(2'b01 << e.r));
            chk(rs_data == e.d, "rs_data", rs_data, e.d);
            chk({rs_parity, rs_par_err} == {e.p, e.e}, "rs_flags",
                32'({rs_parity, rs_par_err}), 32'({e.p, e.e}));
            chk(cyc - dv_cyc == 1, "rs_latency", 32'(cyc - dv_cyc), 1);
            last_data = e.d;
          end
        end
      end
      if (m_data_out_valid) dv_cyc = cyc;
    end
  end

  task automatic push_op(input int r, input logic [15:0] a,
                         input logic [15:0] b, input logic apar,
                         input logic bpar, input bit to,
                         input logic [31:0] d, input logic p,
                         input logic perr, input bit with_resp);
    gq.push_back(r);
    wq.push_back('{a, apar});
    wq.push_back('{b, bpar});
    if (with_resp) rq.push_back('{r, to, d, p, perr});
  endtask

  task automatic set_req(input int r, input logic [15:0] a,
                         input logic [15:0] b, input logic apar,
                         input logic bpar);
    if (r == 0) begin
      a0 = a; b0 = b; ap0 = apar; bp0 = bpar; rqv0 = 1;
    end else begin
      a1 = a; b1 = b; ap1 = apar; bp1 = bpar; rqv1 = 1;
    end
  endtask

  task automatic wait_grant(input int r);
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rq_ready[r]) begin
        got = 1;
        break;
      end
    end
    if (!got) chk(0, "grant_wait", 0, 32'(r));
    @(posedge clk);
    #1;
    if (r == 0) rqv0 = 0;
    else rqv1 = 0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gq.size() == 0 && wq.size() == 0 && rq.size() == 0 &&
          !arb_busy) begin
        done = 1;
        break;
      end
    end
    chk(done, "drain", 32'(rq.size() + wq.size() + gq.size()), 0);
    gq.delete();
    wq.delete();
    rq.delete();
    @(negedge clk);
  endtask

  task automatic single(input int r, input logic [15:0] a,
                        input logic [15:0] b, input logic apar,
                        input logic bpar, input bit to,
                        input logic [31:0] d, input logic p,
                        input logic perr);
    push_op(r, a, b, apar, bpar, to, d, p, perr, 1);
    @(posedge clk);
    #1;
    set_req(r, a, b, apar, bpar);
    wait_grant(r);
    drain();
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk(rq_ready == 2'b00, {tag, "_rq_ready"}, 32'(rq_ready), 0);
    chk(arb_busy == 0, {tag, "_arb_busy"}, 32'(arb_busy), 0);
    chk(m_data_in_valid == 0 && m_data_in == 0, {tag, "_m_data_in"},
        32'({m_data_in_valid, m_data_in}), 0);
    chk(rs_data == 0, {tag, "_rs_data"}, rs_data, 0);
    chk(rs_valid == 0 && rs_timeout == 0, {tag, "_rs_pulses"},
        32'({rs_timeout, rs_valid}), 0);
  endtask

  int nres0;
  bit seen;

  initial begin
    // Both requesters asserted while still in reset.
    set_req(0, 16'd2, 16'd5, 1'b1, 1'b0);
    set_req(1, 16'd7, 16'd6, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    reset_outputs_zero("reset");
    push_op(0, 16'd2, 16'd5, 1, 0, 0, 32'd10, 0, 0, 1);
    push_op(1, 16'd7, 16'd6, 1, 0, 0, 32'd42, 1, 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1;
    fork
      wait_grant(0);
      wait_grant(1);
    join
    drain();

    single(0, 16'h0003, 16'hFFFC, 0, 0, 0, 32'hFFFF_FFF4, 1, 0);

    hold_cnt = 0;
    arm_busy = 5;
    single(1, 16'h0100, 16'h0009, 1, 0, 0, 32'h0000_0900, 0, 0);
    chk(hold_cnt == 5, "busy_hold_cycles", 32'(hold_cnt), 5);

    drop_result = 1;
    single(1, 16'h1234, 16'h0002, 1, 1, 1, 32'h0, 0, 0);
    drop_result = 0;

    single(0, 16'h0005, 16'h0003, 1, 0, 0, 32'h0000_000F, 0, 1);

    // Reset lands mid-operation; its product shows up after release.
    lat = 8;
    push_op(0, 16'h0010, 16'h0010, 1, 1, 0, 32'h0, 0, 0, 0);
    nres0 = n_results;
    @(posedge clk);
    #1;
    set_req(0, 16'h0010, 16'h0010, 1'b1, 1'b1);
    wait_grant(0);
    repeat (2) @(posedge clk);
    #1;
    chk(arb_busy == 1, "in_flight_before_reset", 32'(arb_busy), 1);
    chk(wq.size() == 0, "words_before_reset", 32'(wq.size()), 0);
    rst_n = 0;
    repeat (5) begin
      @(negedge clk);
      reset_outputs_zero("midreset");
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    lat = 2;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (n_results > nres0) begin
        seen = 1;
        break;
      end
    end
    chk(seen, "late_result_arrived", 32'(n_results - nres0), 1);
    repeat (2) begin
      @(negedge clk);
      chk(!arb_busy, "late_result_ignored", 32'(arb_busy), 0);
    end

    push_op(0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 32'h0000_0001, 1, 0, 1);
    push_op(1, 16'h8000, 16'h0002, 1, 1, 0, 32'hFFFF_0000, 0, 0, 1);
    @(posedge clk);
    #1;
    set_req(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    set_req(1, 16'h8000, 16'h0002, 1'b1, 1'b1);
    fork
      wait_grant(0);
      wait_grant(1);
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
